window_serializer_7: RTL and testbench
======================================

Name: window_serializer_7

Overview:
- Parallel-to-serial counterpart of the 7-tap pixel window shift register.
- Accepts one 7-pixel group (tap 0 = newest, tap 6 = oldest) through a valid/ready handshake.
- Emits the group as a serial 8-bit pixel stream, one pixel per accepted beat, restoring original stream order.
- Sits at the output of the noise-filter window stage, re-streaming pixel groups toward the next line/stream consumer.

Parameters:
WIDTH, 8, bit width of each pixel (all din*/dout buses)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
din0  input  WIDTH  tap 0 (newest pixel)
din1  input  WIDTH  tap 1
din2  input  WIDTH  tap 2
din3  input  WIDTH  tap 3
din4  input  WIDTH  tap 4
din5  input  WIDTH  tap 5
din6  input  WIDTH  tap 6 (oldest pixel)
load_valid  input  1  din0..din6 hold a valid group
load_ready  output  1  block can accept a group this cycle
dout  output  WIDTH  serial pixel out
dout_valid  output  1  dout holds a valid pixel
dout_ready  input  1  downstream accepts dout this cycle
dout_last  output  1  current dout is the final pixel of its group
busy  output  1  a group is being emitted

Behaviour:
- Reset (rst low, async): state IDLE, count 0, internal buffer all 0, dout 0, dout_valid 0, dout_last 0, busy 0. load_ready reads 1 in IDLE, but loads are ignored while rst is low.
- Load transfer: load_valid & load_ready at a rising edge.
- Output beat: dout_valid & dout_ready at a rising edge.
- States:
  - IDLE: load_ready=1. On a load transfer, capture all 7 taps into buffer in emit order, count<=0, go SHIFT.
  - SHIFT: dout_valid=1, busy=1.
    - On a beat with count<6: buffer advances one position, count<=count+1.
    - On a beat with count==6 and no load transfer: go IDLE, dout_valid<=0.
    - On a beat with count==6 and a load transfer: capture the new group, count<=0, remain in SHIFT.
- load_ready = (state==IDLE) | (state==SHIFT & count==6 & dout_ready). This is a combinational path from dout_ready to load_ready and is intended.
- Latency: group accepted at edge N → first pixel on dout with dout_valid=1 after edge N.
- Throughput:
  - Minimum 7 cycles per group.
  - Back-to-back groups produce a gapless stream, 7 beats per group, 100% throughput.
- dout and dout_last are registered (buffer head and count==6).
  - dout, dout_valid and dout_last hold stable while dout_valid=1 & dout_ready=0 (backpressure, unlimited duration).
  - Returning to IDLE: dout keeps its last value; dout_last<=0.
- load_valid in SHIFT with count<6 is not accepted. Upstream must hold data until load_ready.
- Reset asserted mid-group: group discarded immediately; all outputs take reset values.
- No arithmetic; count is 3 bits and never exceeds 6.

Optional Feature:
- Macro: WINDOW_SERIALIZER_REVERSE_EN.
- Without it (default): emit order din6, din5, …, din0 (oldest first, original stream order).
- With it: emit order din0, din1, …, din6 (newest first).
- Handshake, latency and dout_last timing are identical in both builds.

Test Plan:
- Reset then single group (din0..din6 = 8'h10..8'h16, default build), dout_ready=1 → dout_valid for 7 cycles, dout = 16,15,14,13,12,11,10; dout_last only on 10; then IDLE with dout_valid=0 and load_ready=1.
- Back-to-back groups A=8'h00..06 and B=8'hA0..A6, load_valid held high, dout_ready=1 → 14 consecutive valid beats with no gap; load_ready pulses exactly on the last beat of A.
- Backpressure: dout_ready toggled 1,0,0,1,… during a group → dout and dout_last stable during stalls; all 7 pixels delivered once, in order; load_ready=0 throughout.
- Async reset asserted mid-group after beat 3 → dout, dout_valid, dout_last, busy go to 0 without a clock edge; a new load after release emits the new group from its first pixel.
- REVERSE_EN build with group 8'h10..8'h16 → dout = 10,11,…,16; dout_last on 16.

Source files
------------

// File: rtl/window_serializer_7.sv
// window_serializer_7: accepts a 7-pixel window group over a valid/ready
// handshake and replays it as a serial pixel stream with a last-pixel flag.
// Optional macro WINDOW_SERIALIZER_REVERSE_EN: when defined, pixels are
// emitted newest-first (din0..din6) instead of oldest-first (din6..din0).
module window_serializer_7 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [WIDTH-1:0] din4,
  input  logic [WIDTH-1:0] din5,
  input  logic [WIDTH-1:0] din6,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                     state;
  state_t                     next_state;
  logic [2:0]                 count;
  logic [2:0]                 next_count;
  logic [6:0][WIDTH-1:0]      buffer;
  logic [6:0][WIDTH-1:0]      next_buffer;
  logic [6:0][WIDTH-1:0]      group;
  logic                       last_q;
  logic                       next_last;
  logic                       load_xfer;
  logic                       beat;

  // Arrange the incoming taps so that buffer slot 0 is the first pixel to emit
  always_comb begin
`ifdef WINDOW_SERIALIZER_REVERSE_EN
    group[0] = din0;
    group[1] = din1;
    group[2] = din2;
    group[3] = din3;
    group[4] = din4;
    group[5] = din5;
    group[6] = din6;
`else
    group[0] = din6;
    group[1] = din5;
    group[2] = din4;
    group[3] = din3;
    group[4] = din2;
    group[5] = din1;
    group[6] = din0;
`endif
  end

  assign load_ready = (state == IDLE) | ((state == SHIFT) & (count == 3'd6) & dout_ready);
  assign load_xfer  = load_valid & load_ready;
  assign dout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign beat       = dout_valid & dout_ready;
  assign dout       = buffer[0];
  assign dout_last  = last_q;

  // State, beat counter, pixel buffer and last flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= 3'd0;
      buffer <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= next_state;
      count  <= next_count;
      buffer <= next_buffer;
      last_q <= next_last;
    end
  end

  // Next-state logic: load a group, advance on each beat, chain or return to idle
  always_comb begin
    next_state  = state;
    next_count  = count;
    next_buffer = buffer;
    next_last   = last_q;
    unique case (state)
      IDLE: begin
        if (load_xfer) begin
          next_state  = SHIFT;
          next_count  = 3'd0;
          next_buffer = group;
          next_last   = 1'b0;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (count != 3'd6) begin
            for (int i = 0; i < 6; i++) begin
              next_buffer[i] = buffer[i+1];
            end
            next_count = count + 3'd1;
            next_last  = (count == 3'd5);
          end else if (load_xfer) begin
            next_buffer = group;
            next_count  = 3'd0;
            next_last   = 1'b0;
          end else begin
            next_state = IDLE;
            next_last  = 1'b0;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_window_serializer_7.sv
// Scoreboard testbench for window_serializer_7: groups accepted by the
// handshake are expanded into expected pixels by a queue model, and a
// monitor compares every output beat. Honours WINDOW_SERIALIZER_REVERSE_EN.
module tb_window_serializer_7;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] pix;
    logic             last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din0, din1, din2, din3, din4, din5, din6;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;

  logic [6:0][WIDTH-1:0] cur_group;
  exp_t                  sb[$];
  int                    checks;
  int                    failures;
  int                    rdy_mode;
  logic                  took;
  logic                  stall_prev;
  logic [WIDTH-1:0]      prev_dout;
  logic                  prev_last;

  assign din0 = cur_group[0];
  assign din1 = cur_group[1];
  assign din2 = cur_group[2];
  assign din3 = cur_group[3];
  assign din4 = cur_group[4];
  assign din5 = cur_group[5];
  assign din6 = cur_group[6];

  window_serializer_7 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .din4       (din4),
    .din5       (din5),
    .din6       (din6),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Expand an accepted group into its expected pixel sequence
  task automatic push_group(input logic [6:0][WIDTH-1:0] g);
    exp_t e;
    for (int k = 0; k < 7; k++) begin
`ifdef WINDOW_SERIALIZER_REVERSE_EN
      e.pix = g[k];
`else
      e.pix = g[6-k];
`endif
      e.last = (k == 6);
      sb.push_back(e);
    end
  endtask

  // Monitor: just before each rising edge, compare outputs against the queue
  task automatic sample();
    exp_t e;
    logic exp_active;
    logic exp_ready;
    if (!rst) begin
      stall_prev = 1'b0;
      return;
    end
    exp_active = (sb.size() != 0);
    exp_ready  = (sb.size() == 0) || ((sb.size() == 1) && dout_ready);
    check_output("dout_valid", dout_valid, exp_active);
    check_output("busy", busy, exp_active);
    check_output("load_ready", load_ready, exp_ready);
    if (stall_prev && dout_valid) begin
      check_output("stall_dout", dout, prev_dout);
      check_output("stall_last", dout_last, prev_last);
    end
    if (dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        check_output("dout", dout, e.pix);
        check_output("dout_last", dout_last, e.last);
      end
    end
    stall_prev = dout_valid && !dout_ready;
    prev_dout  = dout;
    prev_last  = dout_last;
    if (load_valid && load_ready) begin
      push_group(cur_group);
      took = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      sample();
    end
  end

  // Downstream ready generator: always on, 1-0-0 pattern, or random
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1: begin
          dout_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        2: dout_ready = ($urandom_range(0, 3) != 0);
        default: dout_ready = 1'b1;
      endcase
    end
  end

  // Present a group and hold it until the handshake takes it
  task automatic offer_group(input logic [6:0][WIDTH-1:0] g);
    int n;
    cur_group  = g;
    load_valid = 1'b1;
    took = 1'b0;
    n = 0;
    while (!took && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("load_timeout", took, 1);
  endtask

  task automatic drain();
    int n;
    load_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  function automatic logic [6:0][WIDTH-1:0] seq_group(input logic [WIDTH-1:0] base);
    logic [6:0][WIDTH-1:0] g;
    for (int k = 0; k < 7; k++) g[k] = base + WIDTH'(k);
    return g;
  endfunction

  function automatic logic [6:0][WIDTH-1:0] rand_group();
    logic [6:0][WIDTH-1:0] g;
    for (int k = 0; k < 7; k++) g[k] = WIDTH'($urandom);
    return g;
  endfunction

  // Main stimulus sequence
  initial begin
    checks     = 0;
    failures   = 0;
    rdy_mode   = 0;
    took       = 1'b0;
    stall_prev = 1'b0;
    prev_dout  = '0;
    prev_last  = 1'b0;
    rst        = 1'b0;
    load_valid = 1'b0;
    dout_ready = 1'b1;
    cur_group  = '0;

    #2;
    check_output("reset_dout", dout, 0);
    check_output("reset_dout_valid", dout_valid, 0);
    check_output("reset_dout_last", dout_last, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_load_ready", load_ready, 1);

    $display("[TB] loads offered during reset must be ignored");
    cur_group  = seq_group(8'h55);
    load_valid = 1'b1;
    repeat (2) @(negedge clk);
    load_valid = 1'b0;
    #1;
    check_output("reset_ignores_load", dout_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single group");
    offer_group(seq_group(8'h10));
    drain();

    $display("[TB] back-to-back groups");
    offer_group(seq_group(8'h00));
    offer_group(seq_group(8'hA0));
    drain();

    $display("[TB] backpressure pattern");
    rdy_mode = 1;
    offer_group(seq_group(8'h30));
    drain();
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    $display("[TB] async reset mid-group");
    offer_group(seq_group(8'h40));
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    check_output("midrst_dout", dout, 0);
    check_output("midrst_dout_valid", dout_valid, 0);
    check_output("midrst_dout_last", dout_last, 0);
    check_output("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    offer_group(seq_group(8'h60));
    drain();

    $display("[TB] randomized groups");
    for (int r = 0; r < 60; r++) begin
      rdy_mode = (r < 20) ? 2 : ((r < 40) ? 0 : 1);
      offer_group(rand_group());
      if ($urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        repeat ($urandom_range(1, 9)) @(negedge clk);
      end
    end
    rdy_mode = 2;
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
